// File: rtl/typed_text_buffer_pkg.sv
// Shared constants, key encodings and FSM state type for the typed text buffer.
// The packed text format stores 5 bits per slot: 0 = blank, 1..26 = A..Z.
package typed_text_buffer_pkg;

  localparam int CW      = 5;
  localparam int MAX_LEN = 25;
  localparam int TEXT_W  = MAX_LEN * CW;
  localparam int CNT_W   = 6;

  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CW-1:0]    CODE_MAX = CW'(26);

  localparam logic [1:0] KEY_LETTER = 2'd0;
  localparam logic [1:0] KEY_BS     = 2'd1;
  localparam logic [1:0] KEY_ENTER  = 2'd2;
  localparam logic [1:0] KEY_CLR    = 2'd3;

  typedef enum logic [1:0] {
    TYPING = 2'd0,
    SUBMIT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // A letter keystroke only lands in the buffer if its code names A..Z.
  function automatic logic is_letter_code(input logic [CW-1:0] code);
    return (code != '0) && (code <= CODE_MAX);
  endfunction

endpackage

// File: rtl/typed_text_buffer_prefix_match_count.sv
// Combinational count of leading typed slots that equal the target word,
// stopping at the first mismatch or at the typed length.
module prefix_match_count
  import typed_text_buffer_pkg::*;
(
  input  logic [TEXT_W-1:0] text,
  input  logic [TEXT_W-1:0] target,
  input  logic [CNT_W-1:0]  len,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    logic run;
    // NOTE: every variable gets a default before the loop so no path can
    // leave it unassigned and infer a latch.
    count = '0;
    run   = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (run && (CNT_W'(i) < len) &&
          (text[i*CW +: CW] == target[i*CW +: CW])) begin
        count = count + CNT_ONE;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/typed_text_buffer.sv
// Keystroke-driven writer of the packed 25-slot text vector, with a registered
// prefix-correct count and a submit/flush sequence reporting word matches.
module typed_text_buffer
  import typed_text_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [1:0]        key_kind,
  input  logic [CW-1:0]     key_code,
  input  logic [TEXT_W-1:0] target,
  input  logic [CNT_W-1:0]  target_len,
  output logic [TEXT_W-1:0] text,
  output logic [CNT_W-1:0]  len,
  output logic [CNT_W-1:0]  correct,
  output logic              word_done,
  output logic              word_match
);

  state_t           state;
  logic [CNT_W-1:0] match_count;
  logic             accept;

  // Ready depends on state alone so the producer never sees a ready/valid loop.
  assign key_ready = (state == TYPING);
  assign accept    = key_valid && key_ready;

  prefix_match_count u_prefix (
    .text   (text),
    .target (target),
    .len    (len),
    .count  (match_count)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TYPING;
      text       <= '0;
      len        <= '0;
      correct    <= '0;
      word_done  <= 1'b0;
      word_match <= 1'b0;
    end else begin
      correct   <= match_count;
      word_done <= 1'b0;
      unique case (state)
        TYPING: begin
          if (accept) begin
            unique case (key_kind)
              KEY_LETTER: begin
                if (is_letter_code(key_code) && (len < LEN_MAX)) begin
                  text[int'(len)*CW +: CW] <= key_code;
                  len                      <= len + CNT_ONE;
                end
              end
              KEY_BS: begin
                if (len != '0) begin
                  text[(int'(len)-1)*CW +: CW] <= '0;
                  len                          <= len - CNT_ONE;
                end
              end
              KEY_ENTER: state <= SUBMIT;
              KEY_CLR: begin
                text <= '0;
                len  <= '0;
              end
              default: ;
            endcase
          end
        end
        // correct was registered one cycle after the last text change, so it
        // already describes the text being submitted.
        SUBMIT: begin
          word_match <= (len == target_len) && (correct == len);
          word_done  <= 1'b1;
          state      <= FLUSH;
        end
        FLUSH: begin
          text  <= '0;
          len   <= '0;
          state <= TYPING;
        end
        default: state <= TYPING;
      endcase
    end
  end

endmodule
